alu2_op_sequencer: RTL and testbench
====================================

# alu2_op_sequencer

Command sequencer that sits directly upstream of the two-stage ALU (`circuitII_dash`: out = ALU(ALU(x, y, f0), y', f1), with flags zr/ng). It accepts one operation over a valid/ready handshake and holds registered operands and control words on the ALU inputs. It samples the ALU's combinational result, and can iterate the operation N times by feeding the result back as the next x. The final result and flags are returned over a second valid/ready handshake.

## Interface
Parameters:
- `W`, 16, operand/result width (two's complement)
- `CW`, 4, width of iteration count

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_x`, `cmd_y`, `cmd_yd`  in  W each  operands x, y, y'
- `cmd_f0`, `cmd_f1`  in  7 each  control words {zx,nx,zy,ny,f0,f1,no} for stage 1 and stage 2
- `cmd_count`  in  CW  iteration count; 0 is treated as 1
- `alu_x`, `alu_y`, `alu_yd`  out  W each  registered operands to the ALU
- `alu_f0`, `alu_f1`  out  7 each  registered control words to the ALU
- `alu_out`  in  W  ALU result (combinational)
- `alu_zr`, `alu_ng`  in  1 each  ALU flags
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes the result
- `res_out`  out  W  final result
- `res_zr`, `res_ng`  out  1 each  flags of the final iteration
- `res_anyneg`  out  1  sticky flag: ng was seen on any iteration of this command
- `res_iters`  out  CW  number of iterations executed

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, HOLD.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch x/y/yd/f0/f1 into the `alu_*` registers and load remaining = max(`cmd_count`, 1).
  - Clear `res_anyneg`; clear the iteration counter to 0.
  - Go to DRIVE.
- DRIVE: one settle cycle with ALU inputs stable. Then go to CAPTURE.
- CAPTURE: at the ending edge, the FSM samples `alu_out`/`alu_zr`/`alu_ng` into the `res_*` registers.
  - OR `alu_ng` into `res_anyneg`; increment `res_iters`; decrement remaining.
  - If remaining after decrement > 0: `alu_x` ← `alu_out`, then go to DRIVE. y, yd, f0 and f1 are unchanged.
  - Otherwise go to HOLD.
- HOLD
  - `res_valid`=1; `res_*` are stable.
  - On `res_ready`, go to IDLE.
  - `cmd_ready`=0, so a new command is not accepted in the same cycle as result pop.
- `cmd_ready`=1 only in IDLE; `res_valid`=1 only in HOLD.
- Arithmetic is entirely inside the ALU. The sequencer does no width extension; feedback wraps modulo 2^W exactly as the ALU produces it.
- `res_*` registers update only in CAPTURE. They hold their values through HOLD and IDLE until the next command's first CAPTURE.
- Reset (asynchronous, any state including mid-iteration):
  - State returns to IDLE.
  - All `alu_*` and `res_*` outputs go to 0; `res_valid`=0.
  - `cmd_ready` goes to 1 once reset deasserts.
  - The in-flight command is dropped.

## Timing
- Command handshake occurs at edge E0 (`cmd_valid` & `cmd_ready`). `alu_*` are valid from E0.
- Each iteration takes 2 cycles. `res_valid` rises after edge E0+2N, where N = max(`cmd_count`, 1).
- With feedback, the new `alu_x` is visible after the CAPTURE edge, followed by a full DRIVE settle cycle.
- The result handshake occurs at the first edge with `res_valid` & `res_ready`; IDLE is entered after it. Minimum command-to-command spacing is 2N+2 cycles.
- `res_ready` held high in advance: the pop happens at edge E0+2N+1.
- `cmd_valid` asserted outside IDLE is ignored (no latch); the upstream must hold it until ready.

## Test plan
- Both control words 0000100 (add); x=1023, y=2047, y'=1234, count=1 -> `res_valid` after 2 cycles; `res_out`=4304, zr=0, ng=0, iters=1.
- Same operands, count=3 -> `alu_x` sequence 1023, 4304, 7585; `res_out`=10866; `res_valid` after 6 cycles; iters=3.
- x=1000, y=-1234, y'=234, add, count=0 -> treated as 1; `res_out`=0, zr=1, ng=0, anyneg=0.
- Wrap: x=30000, y=2000, y'=1000, add, count=1 -> `res_out`=-32536, ng=1, anyneg=1.
- Back-pressure: hold `res_ready`=0 for 5 cycles; toggle `cmd_valid` with new operands meanwhile -> `res_*` stable, `cmd_ready`=0, new command not latched. Then pulse `res_ready`: IDLE is reached and the next command is accepted one cycle later.
- Assert `rst` during the second DRIVE of a count=3 command -> all outputs 0 immediately and `res_valid` never asserts. After release, a fresh count=1 command completes normally with 4304.

Source files
------------

// File: rtl/alu2_op_sequencer_if.sv
// Command, ALU-drive and result bundle between the op sequencer and its environment.
// The slave modport is the sequencer side; the master modport is the upstream/ALU/consumer side.
interface alu2_op_sequencer_if #(
   parameter int unsigned W  = 16,
   parameter int unsigned CW = 4
);
   localparam int unsigned CTLW = 7;

   logic            cmd_valid;
   logic            cmd_ready;
   logic [W-1:0]    cmd_x;
   logic [W-1:0]    cmd_y;
   logic [W-1:0]    cmd_yd;
   logic [CTLW-1:0] cmd_f0;
   logic [CTLW-1:0] cmd_f1;
   logic [CW-1:0]   cmd_count;

   logic [W-1:0]    alu_x;
   logic [W-1:0]    alu_y;
   logic [W-1:0]    alu_yd;
   logic [CTLW-1:0] alu_f0;
   logic [CTLW-1:0] alu_f1;
   logic [W-1:0]    alu_out;
   logic            alu_zr;
   logic            alu_ng;

   logic            res_valid;
   logic            res_ready;
   logic [W-1:0]    res_out;
   logic            res_zr;
   logic            res_ng;
   logic            res_anyneg;
   logic [CW-1:0]   res_iters;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_yd, cmd_f0, cmd_f1, cmd_count,
      output cmd_ready,
      output alu_x, alu_y, alu_yd, alu_f0, alu_f1,
      input  alu_out, alu_zr, alu_ng,
      output res_valid, res_out, res_zr, res_ng, res_anyneg, res_iters,
      input  res_ready
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_yd, cmd_f0, cmd_f1, cmd_count,
      input  cmd_ready,
      input  alu_x, alu_y, alu_yd, alu_f0, alu_f1,
      output alu_out, alu_zr, alu_ng,
      input  res_valid, res_out, res_zr, res_ng, res_anyneg, res_iters,
      output res_ready
   );
endinterface

// File: rtl/alu2_op_sequencer.sv
// Sequencer in front of the two-stage ALU: latches one command, iterates it N times
// by feeding the ALU result back as x, and returns the final result over a handshake.
module alu2_op_sequencer #(
   parameter int unsigned W  = 16,
   parameter int unsigned CW = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   alu2_op_sequencer_if.slave    bus
);
   localparam int unsigned CTLW = 7;

   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_last;

   logic            r_cmd_ready;
   logic            r_res_valid;
   logic [W-1:0]    r_alu_x;
   logic [W-1:0]    r_alu_y;
   logic [W-1:0]    r_alu_yd;
   logic [CTLW-1:0] r_alu_f0;
   logic [CTLW-1:0] r_alu_f1;
   logic [CW-1:0]   r_remaining;
   logic [CW-1:0]   r_iter_cnt;
   logic            r_anyneg_acc;
   logic [W-1:0]    r_res_out;
   logic            r_res_zr;
   logic            r_res_ng;
   logic            r_res_anyneg;
   logic [CW-1:0]   r_res_iters;
   logic            w_anyneg_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = DRIVE;
            end
         end
         DRIVE:   w_state_nxt = CAPTURE;
         CAPTURE: begin
            w_last      = (r_remaining <= CW'(1));
            w_state_nxt = w_last ? HOLD : DRIVE;
         end
         HOLD: begin
            if (bus.res_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_anyneg_nxt = r_anyneg_acc | bus.alu_ng;

   // Per-command accumulators are separate from res_* so the visible result
   // only changes at a CAPTURE edge, never at command acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_ready  <= 1'b1;
         r_res_valid  <= 1'b0;
         r_alu_x      <= '0;
         r_alu_y      <= '0;
         r_alu_yd     <= '0;
         r_alu_f0     <= '0;
         r_alu_f1     <= '0;
         r_remaining  <= '0;
         r_iter_cnt   <= '0;
         r_anyneg_acc <= 1'b0;
         r_res_out    <= '0;
         r_res_zr     <= 1'b0;
         r_res_ng     <= 1'b0;
         r_res_anyneg <= 1'b0;
         r_res_iters  <= '0;
      end else begin
         r_cmd_ready <= (w_state_nxt == IDLE);
         r_res_valid <= (w_state_nxt == HOLD);
         if (w_accept) begin
            r_alu_x      <= bus.cmd_x;
            r_alu_y      <= bus.cmd_y;
            r_alu_yd     <= bus.cmd_yd;
            r_alu_f0     <= bus.cmd_f0;
            r_alu_f1     <= bus.cmd_f1;
            r_remaining  <= (bus.cmd_count == '0) ? CW'(1) : bus.cmd_count;
            r_iter_cnt   <= '0;
            r_anyneg_acc <= 1'b0;
         end
         if (r_state == CAPTURE) begin
            r_res_out    <= bus.alu_out;
            r_res_zr     <= bus.alu_zr;
            r_res_ng     <= bus.alu_ng;
            r_res_anyneg <= w_anyneg_nxt;
            r_anyneg_acc <= w_anyneg_nxt;
            r_res_iters  <= r_iter_cnt + CW'(1);
            r_iter_cnt   <= r_iter_cnt + CW'(1);
            r_remaining  <= r_remaining - CW'(1);
            if (!w_last) r_alu_x <= bus.alu_out;
         end
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.res_valid  = r_res_valid;
   assign bus.alu_x      = r_alu_x;
   assign bus.alu_y      = r_alu_y;
   assign bus.alu_yd     = r_alu_yd;
   assign bus.alu_f0     = r_alu_f0;
   assign bus.alu_f1     = r_alu_f1;
   assign bus.res_out    = r_res_out;
   assign bus.res_zr     = r_res_zr;
   assign bus.res_ng     = r_res_ng;
   assign bus.res_anyneg = r_res_anyneg;
   assign bus.res_iters  = r_res_iters;
endmodule

// File: tb/tb_alu2_op_sequencer.sv
// Bench for alu2_op_sequencer: behavioural two-stage ALU, vector table with a result
// scoreboard, plus hand sequences for feedback, back-pressure and mid-command reset.
module tb_alu2_op_sequencer;
   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;
   localparam logic [6:0] ADD  = 7'b0000100;
   localparam logic [6:0] ZADD = 7'b1000100;
   localparam logic [6:0] NADD = 7'b0000101;

   typedef struct {
      logic [W-1:0]  x, y, yd;
      logic [6:0]    f0, f1;
      logic [CW-1:0] cnt;
      logic [W-1:0]  eo;
      logic          ezr, eng, eany;
      logic [CW-1:0] eit;
   } vec_t;

   typedef struct {
      logic [W-1:0]  out;
      logic          zr, ng, any;
      logic [CW-1:0] it;
      int            cycles;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc_since;
   int   acc_wait;
   sb_t  sb_q[$];
   vec_t vecs[8];

   always #5 clk = ~clk;

   alu2_op_sequencer_if #(.W(W), .CW(CW)) bus();
   alu2_op_sequencer #(.W(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Hack-style stage: {zx,nx,zy,ny,add,or_sel,no}
   function automatic logic [W-1:0] alu_stage(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [6:0] c);
      logic [W-1:0] a, b, o;
      a = c[6] ? '0 : x;
      if (c[5]) a = ~a;
      b = c[4] ? '0 : y;
      if (c[3]) b = ~b;
      o = c[2] ? a + b : (c[1] ? (a | b) : (a & b));
      if (c[0]) o = ~o;
      return o;
   endfunction

   logic [W-1:0] w_alu;
   assign w_alu       = alu_stage(alu_stage(bus.alu_x, bus.alu_y, bus.alu_f0), bus.alu_yd, bus.alu_f1);
   assign bus.alu_out = w_alu;
   assign bus.alu_zr  = (w_alu == '0);
   assign bus.alu_ng  = w_alu[W-1];

   function automatic vec_t with_expect(input vec_t v);
      vec_t r;
      logic [W-1:0] xx, o;
      int n;
      r = v;
      xx = v.x;
      o = '0;
      r.eany = 1'b0;
      n = (v.cnt == '0) ? 1 : int'(v.cnt);
      for (int i = 0; i < n; i++) begin
         o = alu_stage(alu_stage(xx, v.y, v.f0), v.yd, v.f1);
         r.eany = r.eany | o[W-1];
         xx = o;
      end
      r.eo  = o;
      r.ezr = (o == '0);
      r.eng = o[W-1];
      r.eit = CW'(n);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_since++;
   endtask

   task automatic send_cmd(input vec_t v, input bit push, input string tag);
      sb_t e;
      int n;
      bus.cmd_x = v.x; bus.cmd_y = v.y; bus.cmd_yd = v.yd;
      bus.cmd_f0 = v.f0; bus.cmd_f1 = v.f1; bus.cmd_count = v.cnt;
      bus.cmd_valid = 1'b1;
      acc_wait = 0;
      while (bus.cmd_ready !== 1'b1 && acc_wait < 50) begin tick(); acc_wait++; end
      chk({tag, " accept_timeout"}, 32'(acc_wait < 50), 32'd1);
      tick();
      cyc_since = 0;
      bus.cmd_valid = 1'b0;
      chk({tag, " alu_x@E0"}, 32'(bus.alu_x), 32'(v.x));
      if (push) begin
         n = (v.cnt == '0) ? 1 : int'(v.cnt);
         e.out = v.eo; e.zr = v.ezr; e.ng = v.eng; e.any = v.eany; e.it = v.eit;
         e.cycles = 2 * n;
         sb_q.push_back(e);
      end
   endtask

   task automatic collect(input string tag);
      sb_t e;
      int bound;
      bound = 0;
      while (bus.res_valid !== 1'b1 && bound < 64) begin tick(); bound++; end
      if (bus.res_valid !== 1'b1) begin
         chk({tag, " res_valid_timeout"}, 32'(bus.res_valid), 32'd1);
      end else if (sb_q.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, " res_out"},    32'(bus.res_out),    32'(e.out));
         chk({tag, " res_zr"},     32'(bus.res_zr),     32'(e.zr));
         chk({tag, " res_ng"},     32'(bus.res_ng),     32'(e.ng));
         chk({tag, " res_anyneg"}, 32'(bus.res_anyneg), 32'(e.any));
         chk({tag, " res_iters"},  32'(bus.res_iters),  32'(e.it));
         chk({tag, " latency"},    32'(cyc_since),      32'(e.cycles));
      end
   endtask

   task automatic pop_res(input string tag);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk({tag, " res_valid_after_pop"}, 32'(bus.res_valid), 32'd0);
      chk({tag, " cmd_ready_after_pop"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      vec_t v;
      int   seen;
      logic [W-1:0] hold_out;

      // {x, y, yd, f0, f1, cnt, eo, ezr, eng, eany, eit}
      vecs[0] = '{16'd1023, 16'd2047, 16'd1234, ADD, ADD, 4'd1, 16'd4304, 1'b0, 1'b0, 1'b0, 4'd1};
      vecs[1] = '{16'd1000, 16'hFB2E, 16'd234, ADD, ADD, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 4'd1};
      vecs[2] = '{16'd30000, 16'd2000, 16'd1000, ADD, ADD, 4'd1, 16'h80E8, 1'b0, 1'b1, 1'b1, 4'd1};
      vecs[3] = '{16'hFFFB, 16'd1, 16'd1, ADD, ADD, 4'd4, 16'd3, 1'b0, 1'b0, 1'b1, 4'd4};
      vecs[4] = '{16'd0, 16'd1, 16'd1, ADD, ADD, 4'd15, 16'd30, 1'b0, 1'b0, 1'b0, 4'd15};
      vecs[5] = '{16'd777, 16'd5, 16'd6, ZADD, ADD, 4'd2, 16'd11, 1'b0, 1'b0, 1'b0, 4'd2};
      vecs[6] = with_expect('{W'($urandom), W'($urandom), W'($urandom), ADD, ADD,
                              CW'($urandom_range(0, 15)), '0, 1'b0, 1'b0, 1'b0, '0});
      vecs[7] = with_expect('{W'($urandom), W'($urandom), W'($urandom), NADD, ADD,
                              CW'($urandom_range(2, 9)), '0, 1'b0, 1'b0, 1'b0, '0});

      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
      bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_yd = '0;
      bus.cmd_f0 = '0; bus.cmd_f1 = '0; bus.cmd_count = '0;
      cyc_since = 0;
      tick(); tick();
      chk("rst alu_x", 32'(bus.alu_x), 32'd0);
      chk("rst alu_f0", 32'(bus.alu_f0), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst res_out", 32'(bus.res_out), 32'd0);
      chk("rst res_iters", 32'(bus.res_iters), 32'd0);

      for (int i = 0; i < 8; i++) begin
         send_cmd(vecs[i], 1'b1, $sformatf("vec%0d", i));
         collect($sformatf("vec%0d", i));
         pop_res($sformatf("vec%0d", i));
      end

      // Feedback: alu_x must walk through each intermediate result.
      v = vecs[0];
      v.cnt = 4'd3; v.eo = 16'd10866; v.eit = 4'd3;
      send_cmd(v, 1'b1, "iter3");
      tick(); tick();
      chk("iter3 alu_x#2", 32'(bus.alu_x), 32'd4304);
      chk("iter3 alu_y", 32'(bus.alu_y), 32'd2047);
      tick(); tick();
      chk("iter3 alu_x#3", 32'(bus.alu_x), 32'd7585);
      collect("iter3");
      pop_res("iter3");

      // Back-pressure: result held, new commands ignored while in HOLD.
      send_cmd(vecs[0], 1'b1, "bp");
      collect("bp");
      hold_out = bus.res_out;
      for (int i = 0; i < 5; i++) begin
         bus.cmd_valid = i[0] ? 1'b0 : 1'b1;
         bus.cmd_x = W'(111 + i);
         tick();
         chk("bp res_valid", 32'(bus.res_valid), 32'd1);
         chk("bp cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp res_out", 32'(bus.res_out), 32'(hold_out));
         chk("bp alu_x", 32'(bus.alu_x), 32'd1023);
      end
      bus.cmd_valid = 1'b0;
      pop_res("bp");
      chk("bp res_out_idle", 32'(bus.res_out), 32'd4304);
      send_cmd(vecs[3], 1'b1, "bp_next");
      chk("bp_next accept_wait", 32'(acc_wait), 32'd0);
      collect("bp_next");
      pop_res("bp_next");

      // Reset in the second DRIVE of a three-iteration command.
      v = vecs[0];
      v.cnt = 4'd3;
      send_cmd(v, 1'b0, "rstmid");
      tick(); tick();
      chk("rstmid alu_x_pre", 32'(bus.alu_x), 32'd4304);
      chk("rstmid res_out_pre", 32'(bus.res_out), 32'd4304);
      rst = 1'b1;
      #1;
      chk("rstmid alu_x", 32'(bus.alu_x), 32'd0);
      chk("rstmid alu_yd", 32'(bus.alu_yd), 32'd0);
      chk("rstmid res_out", 32'(bus.res_out), 32'd0);
      chk("rstmid res_iters", 32'(bus.res_iters), 32'd0);
      chk("rstmid res_valid", 32'(bus.res_valid), 32'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.res_valid === 1'b1) seen++;
      end
      chk("rstmid res_valid_seen", 32'(seen), 32'd0);
      chk("rstmid cmd_ready", 32'(bus.cmd_ready), 32'd1);
      send_cmd(vecs[0], 1'b1, "post_rst");
      collect("post_rst");
      pop_res("post_rst");

      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
